// File: rtl/mmio_mailbox.sv
// MMIO byte mailbox on the picorv32 native bus: RX (host->CPU) and TX (CPU->host) FIFOs.
// Optional MBOX_IRQ_EN adds the CTRL.irq_en bit and a registered irq output.
module mmio_mailbox #(
   parameter int FIFO_AW     = 4,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic [3:0]  mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   input  logic [7:0]  h_rx_data,
   input  logic        h_rx_valid,
   output logic [7:0]  h_tx_data,
   output logic        h_tx_valid,
   input  logic        h_tx_ready
`ifdef MBOX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t state, state_nxt;
   logic [2:0]  wcnt, wcnt_nxt;
   logic [1:0]  addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         wcnt    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (state == S_IDLE && mem_valid) begin
            addr_q  <= mem_addr[3:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      unique case (state)
         S_IDLE: begin
            if (mem_valid) begin
               wcnt_nxt  = 3'(WAIT_STATES);
               state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
            end
         end
         S_WAIT: begin
            // A dropped request is abandoned before any side effect lands
            if (!mem_valid)
               state_nxt = S_IDLE;
            else if (wcnt <= 3'd1)
               state_nxt = S_ACK;
            else
               wcnt_nxt = wcnt - 3'd1;
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   logic ack, rd, wr;
   logic sel_data, sel_status, sel_ctrl, sel_scratch;

   assign ack         = (state == S_ACK);
   assign rd          = ack && (wstrb_q == 4'b0000);
   assign wr          = ack && (wstrb_q != 4'b0000);
   assign sel_data    = (addr_q == 2'd0);
   assign sel_status  = (addr_q == 2'd1);
   assign sel_ctrl    = (addr_q == 2'd2);
   assign sel_scratch = (addr_q == 2'd3);
   assign mem_ready   = ack;

   logic [7:0]         rx_mem [DEPTH];
   logic [FIFO_AW:0]   rx_wp, rx_rp, rx_cnt;
   logic               rx_empty, rx_full, rx_push, rx_pop;
   logic [7:0]         rx_head;

   assign rx_cnt   = rx_wp - rx_rp;
   assign rx_empty = (rx_cnt == '0);
   assign rx_full  = (rx_cnt == FULL_CNT);
   assign rx_head  = rx_mem[rx_rp[FIFO_AW-1:0]];
   assign rx_pop   = rd && sel_data && !rx_empty;
   assign rx_push  = h_rx_valid && (!rx_full || rx_pop);

   logic [7:0]         tx_mem [DEPTH];
   logic [FIFO_AW:0]   tx_wp, tx_rp, tx_cnt;
   logic               tx_empty, tx_full, tx_req, tx_push, tx_pop;

   assign tx_cnt     = tx_wp - tx_rp;
   assign tx_empty   = (tx_cnt == '0);
   assign tx_full    = (tx_cnt == FULL_CNT);
   assign h_tx_valid = !tx_empty;
   assign h_tx_data  = tx_mem[tx_rp[FIFO_AW-1:0]];
   assign tx_pop     = h_tx_valid && h_tx_ready;
   assign tx_req     = wr && sel_data && wstrb_q[0];
   assign tx_push    = tx_req && (!tx_full || tx_pop);

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= h_rx_data;
      if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= wdata_q[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_wp <= '0;
         rx_rp <= '0;
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end
   end

   logic rx_ovf, tx_ovf, rx_under, clr;

   assign clr = wr && sel_status && wstrb_q[0];

   // A new event in the same cycle as a clear wins, so it is never lost
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_ovf   <= 1'b0;
         tx_ovf   <= 1'b0;
         rx_under <= 1'b0;
      end else begin
         rx_ovf   <= (h_rx_valid && rx_full && !rx_pop)
                     || (rx_ovf && !(clr && wdata_q[2]));
         tx_ovf   <= (tx_req && tx_full && !tx_pop)
                     || (tx_ovf && !(clr && wdata_q[3]));
         rx_under <= (rd && sel_data && rx_empty)
                     || (rx_under && !(clr && wdata_q[4]));
      end
   end

   logic [31:0] scratch;

   always_ff @(posedge clk) begin
      if (reset) begin
         scratch <= '0;
      end else if (wr && sel_scratch) begin
         for (int i = 0; i < 4; i++)
            if (wstrb_q[i]) scratch[8*i +: 8] <= wdata_q[8*i +: 8];
      end
   end

   logic irq_en;

`ifdef MBOX_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr && sel_ctrl && wstrb_q[0]) irq_en <= wdata_q[0];
         irq <= irq_en && !rx_empty;
      end
   end
`else
   assign irq_en = 1'b0;
`endif

   logic [31:0] status;

   assign status = {8'h00, 8'(tx_cnt), 8'(rx_cnt),
                    3'b000, rx_under, tx_ovf, rx_ovf, tx_full, !rx_empty};

   always_comb begin
      mem_rdata = '0;
      if (ack) begin
         unique case (addr_q)
            2'd0: mem_rdata = {24'h0, rx_empty ? 8'h00 : rx_head};
            2'd1: mem_rdata = status;
            2'd2: mem_rdata = {31'h0, irq_en};
            2'd3: mem_rdata = scratch;
         endcase
      end
   end

   logic unused_addr;
   assign unused_addr = ^mem_addr[1:0];

endmodule

// File: tb/tb_mmio_mailbox.sv
// Directed bench for mmio_mailbox: bus latency, register map, FIFO edges, abort/reset.
// Define MBOX_IRQ_EN at build time to also exercise the irq output.
module tb_mmio_mailbox;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic [3:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [7:0]  h_rx_data;
   logic        h_rx_valid;
   logic [7:0]  h_tx_data;
   logic        h_tx_valid;
   logic        h_tx_ready;
`ifdef MBOX_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   mmio_mailbox #(.FIFO_AW(4), .WAIT_STATES(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_valid  (mem_valid),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .h_rx_data  (h_rx_data),
      .h_rx_valid (h_rx_valid),
      .h_tx_data  (h_tx_data),
      .h_tx_valid (h_tx_valid),
      .h_tx_ready (h_tx_ready)
`ifdef MBOX_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   localparam logic [3:0] A_DATA = 4'h0;
   localparam logic [3:0] A_STAT = 4'h4;
   localparam logic [3:0] A_CTRL = 4'h8;
   localparam logic [3:0] A_SCR  = 4'hC;

   int n_tests = 0;
   int n_fail  = 0;
   int idle_leak = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus(input logic [3:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd,
                      output int lat);
      rd  = '0;
      lat = -1;
      @(negedge clk);
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      mem_valid = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (mem_ready) begin
            rd  = mem_rdata;
            lat = n;
            break;
         end
         if (mem_rdata != 32'h0) idle_leak++;
      end
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      if (lat < 0) chk("bus_timeout", 32'h0, 32'h1);
   endtask

   task automatic rd_reg(input string tag, input logic [3:0] a,
                         input logic [31:0] exp);
      logic [31:0] d;
      int l;
      bus(a, 32'h0, 4'h0, d, l);
      chk(tag, d, exp);
   endtask

   task automatic wr_reg(input logic [3:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
      logic [31:0] d;
      int l;
      bus(a, wd, ws, d, l);
   endtask

   task automatic host_push(input logic [7:0] b);
      @(negedge clk);
      h_rx_data  = b;
      h_rx_valid = 1'b1;
      @(negedge clk);
      h_rx_valid = 1'b0;
   endtask

   logic [31:0] d;
   int          lat;
   int          rdy_seen;

   initial begin
      reset      = 1'b1;
      mem_valid  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      h_rx_data  = '0;
      h_rx_valid = 1'b0;
      h_tx_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(mem_ready), 32'h0);
      chk("rst_rdata", mem_rdata, 32'h0);
      chk("rst_txvalid", 32'(h_tx_valid), 32'h0);
`ifdef MBOX_IRQ_EN
      chk("rst_irq", 32'(irq), 32'h0);
`endif
      reset = 1'b0;

      // Latency and reset value of SCRATCH
      bus(A_SCR, 32'h0, 4'h0, d, lat);
      chk("lat_scratch", 32'(lat), 32'd2);
      chk("scratch_rst", d, 32'h0);

      // Byte strobes
      wr_reg(A_SCR, 32'hDEADBEEF, 4'b0101);
      rd_reg("scratch_strb", A_SCR, 32'h00AD00EF);

      // RX path and underflow
      host_push(8'h41);
      host_push(8'h42);
      rd_reg("stat_rx2", A_STAT, 32'h00000201);
      rd_reg("rx_b0", A_DATA, 32'h41);
      rd_reg("rx_b1", A_DATA, 32'h42);
      rd_reg("rx_empty_rd", A_DATA, 32'h0);
      rd_reg("stat_under", A_STAT, 32'h00000010);
      wr_reg(A_STAT, 32'h10, 4'h1);
      rd_reg("stat_under_clr", A_STAT, 32'h0);

      // RX overflow: 17 pushes, last one dropped
      for (int i = 0; i < 17; i++) host_push(8'(i));
      rd_reg("stat_rx_full", A_STAT, 32'h00001005);

      // Host push coinciding with CPU pop while full
      @(negedge clk);
      mem_addr  = A_DATA;
      mem_wstrb = 4'h0;
      mem_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("full_pp_ready", 32'(mem_ready), 32'h1);
      chk("full_pp_data", mem_rdata, 32'h00);
      h_rx_data  = 8'hAA;
      h_rx_valid = 1'b1;
      mem_valid  = 1'b0;
      @(negedge clk);
      h_rx_valid = 1'b0;
      rd_reg("stat_pp_full", A_STAT, 32'h00001005);
      for (int i = 0; i < 16; i++)
         rd_reg($sformatf("drain%0d", i), A_DATA,
                (i < 15) ? 32'(i + 1) : 32'hAA);
      wr_reg(A_STAT, 32'h1C, 4'h1);
      rd_reg("stat_drained", A_STAT, 32'h0);

      // TX path with backpressure
      wr_reg(A_DATA, 32'h00000055, 4'h1);
      @(negedge clk);
      chk("tx_valid", 32'(h_tx_valid), 32'h1);
      chk("tx_data", 32'(h_tx_data), 32'h55);
      rd_reg("stat_tx1", A_STAT, 32'h00010000);
      chk("tx_data_hold", 32'(h_tx_data), 32'h55);
      @(negedge clk);
      h_tx_ready = 1'b1;
      @(negedge clk);
      h_tx_ready = 1'b0;
      chk("tx_popped", 32'(h_tx_valid), 32'h0);
      rd_reg("stat_tx0", A_STAT, 32'h0);
      wr_reg(A_DATA, 32'h00000066, 4'b0010);
      rd_reg("stat_nostrb0", A_STAT, 32'h0);

      // Abort in WAIT
      rdy_seen = 0;
      @(negedge clk);
      mem_addr  = A_DATA;
      mem_wdata = 32'h77;
      mem_wstrb = 4'h1;
      mem_valid = 1'b1;
      @(negedge clk);
      mem_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (mem_ready) rdy_seen++;
      end
      chk("abort_noready", 32'(rdy_seen), 32'h0);
      rd_reg("abort_stat", A_STAT, 32'h0);

      // Reset in WAIT with both FIFOs occupied
      host_push(8'h11);
      wr_reg(A_DATA, 32'h22, 4'h1);
      rd_reg("prerst_stat", A_STAT, 32'h00010101);
      rdy_seen = 0;
      @(negedge clk);
      mem_addr  = A_SCR;
      mem_wstrb = 4'h0;
      mem_valid = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      if (mem_ready) rdy_seen++;
      reset     = 1'b0;
      mem_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (mem_ready) rdy_seen++;
      end
      chk("rst_noready", 32'(rdy_seen), 32'h0);
      chk("rst_txempty", 32'(h_tx_valid), 32'h0);
      rd_reg("rst_stat", A_STAT, 32'h0);
      rd_reg("rst_scratch", A_SCR, 32'h0);

`ifdef MBOX_IRQ_EN
      wr_reg(A_CTRL, 32'h1, 4'h1);
      rd_reg("ctrl_rd", A_CTRL, 32'h1);
      @(negedge clk);
      h_rx_data  = 8'h5A;
      h_rx_valid = 1'b1;
      @(negedge clk);
      h_rx_valid = 1'b0;
      chk("irq_lag", 32'(irq), 32'h0);
      @(negedge clk);
      chk("irq_set", 32'(irq), 32'h1);
`else
      wr_reg(A_CTRL, 32'hFFFFFFFF, 4'hF);
      rd_reg("ctrl_rd0", A_CTRL, 32'h0);
`endif

      chk("rdata_idle_zero", 32'(idle_leak), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
